pipe_adder: RTL and testbench

PIPE_ADDER -- requirements
Module: pipe_adder

---
 rtl/pipe_adder_pkg.sv | 13 +
 rtl/pipe_adder_slice.sv | 25 ++
 rtl/pipe_adder.sv | 117 +++++++++++
 tb/tb_pipe_adder.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_adder_pkg.sv
// Shared constants for the pipelined adder: default geometry and the
// add/subtract mode encoding carried on the sub input.
package pipe_adder_pkg;

    localparam int DEF_WIDTH  = 16;
    localparam int DEF_STAGES = 4;

    typedef enum logic {
        MODE_ADD = 1'b0,
        MODE_SUB = 1'b1
    } mode_e;

endpackage

// File: rtl/pipe_adder_slice.sv
// One SLICE-bit ripple segment of the pipelined adder. Besides the sum and
// carry-out it exposes the carry into its own MSB, which the top level needs
// from the most significant slice to form signed overflow.
module pipe_adder_slice
    import pipe_adder_pkg::*;
#(
    parameter int SLICE = DEF_WIDTH / DEF_STAGES
) (
    input  logic [SLICE-1:0] a,
    input  logic [SLICE-1:0] b,
    input  logic             ci,
    output logic [SLICE-1:0] s,
    output logic             co,
    output logic             msb_ci
);

    logic [SLICE:0] sum;

    assign sum    = {1'b0, a} + {1'b0, b} + {{SLICE{1'b0}}, ci};
    assign s      = sum[SLICE-1:0];
    assign co     = sum[SLICE];
    // sum bit = a ^ b ^ carry_in, so the carry into the MSB falls out directly
    assign msb_ci = a[SLICE-1] ^ b[SLICE-1] ^ sum[SLICE-1];

endmodule

// File: rtl/pipe_adder.sv
// Pipelined WIDTH-bit adder/subtractor. Stage k adds operand slice k using
// the carry registered by stage k-1; operands and partial sums travel with
// each entry so a result leaves STAGES cycles after acceptance. A stalled
// output freezes the whole pipe (no bubble squeezing). WIDTH must be an
// integer multiple of STAGES.
module pipe_adder
    import pipe_adder_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int STAGES = DEF_STAGES
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             co,
    output logic             ovf
);

    localparam int SLICE = WIDTH / STAGES;
    localparam int LAST  = STAGES - 1;

    // Stage registers: valid, operands (b already conditioned for subtract),
    // accumulated sum, slice carry-out and the MSB carry-in tap.
    logic             vld_p [STAGES];
    logic [WIDTH-1:0] a_p   [STAGES];
    logic [WIDTH-1:0] b_p   [STAGES];
    logic [WIDTH-1:0] s_p   [STAGES];
    logic             c_p   [STAGES];
    logic             m_p   [STAGES];

    // Per-stage combinational inputs and slice results
    logic [WIDTH-1:0] a_in  [STAGES];
    logic [WIDTH-1:0] b_in  [STAGES];
    logic [WIDTH-1:0] s_in  [STAGES];
    logic             c_in  [STAGES];
    logic [WIDTH-1:0] s_nxt [STAGES];
    logic [SLICE-1:0] sl_s  [STAGES];
    logic             sl_co [STAGES];
    logic             sl_m  [STAGES];

    logic advance;

    assign in_ready = !(out_valid && !out_ready);
    assign advance  = in_ready;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        if (k == 0) begin : g_first
            // Stage 0 boundary: subtract is a + ~b + 1, ci only used for add
            assign a_in[k] = a;
            assign b_in[k] = (sub == MODE_SUB) ? ~b : b;
            assign c_in[k] = (sub == MODE_SUB) ? 1'b1 : ci;
            assign s_in[k] = '0;
        end else begin : g_next
            // Stage k boundary: consume everything registered by stage k-1
            assign a_in[k] = a_p[k-1];
            assign b_in[k] = b_p[k-1];
            assign c_in[k] = c_p[k-1];
            assign s_in[k] = s_p[k-1];
        end

        pipe_adder_slice #(
            .SLICE (SLICE)
        ) u_slice (
            .a      (a_in[k][k*SLICE +: SLICE]),
            .b      (b_in[k][k*SLICE +: SLICE]),
            .ci     (c_in[k]),
            .s      (sl_s[k]),
            .co     (sl_co[k]),
            .msb_ci (sl_m[k])
        );

        // Drop this stage's slice into the running sum, keep lower slices
        assign s_nxt[k] = (s_in[k] & ~(WIDTH'({SLICE{1'b1}}) << (k * SLICE)))
                        | (WIDTH'(sl_s[k]) << (k * SLICE));
    end

    // Advance every stage together when the output is not stalled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < STAGES; k++) begin
                vld_p[k] <= 1'b0;
                a_p[k]   <= '0;
                b_p[k]   <= '0;
                s_p[k]   <= '0;
                c_p[k]   <= 1'b0;
                m_p[k]   <= 1'b0;
            end
        end else if (advance) begin
            vld_p[0] <= in_valid;
            for (int k = 1; k < STAGES; k++) begin
                vld_p[k] <= vld_p[k-1];
            end
            for (int k = 0; k < STAGES; k++) begin
                a_p[k] <= a_in[k];
                b_p[k] <= b_in[k];
                s_p[k] <= s_nxt[k];
                c_p[k] <= sl_co[k];
                m_p[k] <= sl_m[k];
            end
        end
    end

    // Output boundary: last stage holds the finished result
    assign out_valid = vld_p[LAST];
    assign s         = s_p[LAST];
    assign co        = c_p[LAST];
    assign ovf       = c_p[LAST] ^ m_p[LAST];

endmodule

// File: tb/tb_pipe_adder.sv
// Bench for pipe_adder (WIDTH=16, STAGES=4): directed cases, back-to-back,
// stall, mid-flight reset and a long randomized run against a scoreboard.
module tb_pipe_adder;
    import pipe_adder_pkg::*;

    localparam int W  = 16;
    localparam int ST = 4;

    logic         clk       = 1'b0;
    logic         rst_n     = 1'b0;
    logic         in_valid  = 1'b0;
    logic         ci        = 1'b0;
    logic         sub       = 1'b0;
    logic         out_ready = 1'b1;
    logic [W-1:0] a         = '0;
    logic [W-1:0] b         = '0;
    logic         in_ready;
    logic         out_valid;
    logic [W-1:0] s;
    logic         co;
    logic         ovf;

    int total = 0;
    int bad   = 0;
    int n_out = 0;

    logic [17:0] sb_q[$];
    logic        prev_stall = 1'b0;
    logic [17:0] prev_out   = '0;

    pipe_adder #(
        .WIDTH  (W),
        .STAGES (ST)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .ci        (ci),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .s         (s),
        .co        (co),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, bad=%0d", bad);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: plain integer arithmetic, result packed as {ovf, co, s}
    function automatic logic [17:0] model(input logic [15:0] xa, input logic [15:0] xb,
                                          input logic xci, input logic xsub);
        int      ua, ub, sa, sb, full, sres;
        logic    rco;
        logic [15:0] rs;
        ua = int'(xa);
        ub = int'(xb);
        sa = int'($signed(xa));
        sb = int'($signed(xb));
        if (xsub) begin
            full = ua - ub;
            rco  = (ua >= ub);
            sres = sa - sb;
        end else begin
            full = ua + ub + int'(xci);
            rco  = (full > 65535);
            sres = sa + sb + int'(xci);
        end
        rs = 16'(full);
        return {(sres > 32767 || sres < -32768), rco, rs};
    endfunction

    // Monitor / scoreboard, sampled on the falling edge
    initial begin
        logic [17:0] exp;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                sb_q.delete();
                prev_stall = 1'b0;
            end else begin
                check("in_ready", 32'(in_ready), 32'(!(out_valid && !out_ready)));
                if (prev_stall)
                    check("stall_hold", 32'({ovf, co, s, out_valid}), 32'({prev_out, 1'b1}));
                if (out_valid && out_ready) begin
                    if (sb_q.size() == 0) begin
                        check("unexpected_out", 32'(out_valid), 32'(0));
                    end else begin
                        exp = sb_q.pop_front();
                        check("result", 32'({ovf, co, s}), 32'(exp));
                        n_out++;
                    end
                end
                if (in_valid && in_ready)
                    sb_q.push_back(model(a, b, ci, sub));
                prev_stall = out_valid && !out_ready;
                prev_out   = {ovf, co, s};
            end
        end
    end

    task automatic send(input logic [15:0] xa, input logic [15:0] xb, input logic xci, input logic xsub);
        bit ok = 0;
        a = xa; b = xb; ci = xci; sub = xsub;
        in_valid = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1;
                break;
            end
        end
        if (!ok) check("send_timeout", 32'(in_ready), 32'(1));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_out(input string name, output int lat);
        lat = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            lat++;
            if (out_valid) break;
        end
        if (!out_valid) check({name, "_timeout"}, 32'(out_valid), 32'(1));
    endtask

    task automatic run_one(input string name, input logic [15:0] xa, input logic [15:0] xb,
                           input logic xci, input logic xsub,
                           input logic [15:0] es, input logic eco, input logic eovf);
        int lat;
        out_ready = 1'b1;
        send(xa, xb, xci, xsub);
        wait_out(name, lat);
        check({name, "_lat"}, 32'(lat), 32'(ST));
        check({name, "_val"}, 32'({ovf, co, s}), 32'({eovf, eco, es}));
        @(posedge clk);
        #1;
    endtask

    initial begin
        int cnt, first, last, lat, start;

        // Reset state while rst_n is held low
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", 32'(out_valid), 32'(0));
        check("rst_s", 32'(s), 32'(0));
        check("rst_co_ovf", 32'({co, ovf}), 32'(0));
        check("rst_in_ready", 32'(in_ready), 32'(1));
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Directed arithmetic cases
        run_one("add_ci",   16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0, 1'b0);
        run_one("add_ovf",  16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
        run_one("sub_neg",  16'h0003, 16'h0005, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0);
        run_one("wrap",     16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        run_one("sub_ci",   16'h0005, 16'h0003, 1'b1, 1'b1, 16'h0002, 1'b1, 1'b0);
        run_one("sub_ovf",  16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);

        // Back-to-back: 8 operand sets, expect 8 consecutive results
        out_ready = 1'b1;
        cnt = 0; first = -1; last = -1;
        for (int i = 0; i < 8 + ST + 4; i++) begin
            if (i < 8) begin
                in_valid = 1'b1;
                a = 16'($urandom); b = 16'($urandom);
                ci = 1'($urandom); sub = 1'($urandom);
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
            if (out_valid) begin
                cnt++;
                if (first < 0) first = i;
                last = i;
            end
            @(posedge clk);
            #1;
        end
        check("b2b_count", 32'(cnt), 32'(8));
        check("b2b_contig", 32'(last - first + 1), 32'(8));
        check("b2b_first", 32'(first), 32'(ST));

        // Stall: hold the output for 3 cycles while offering more input
        out_ready = 1'b0;
        send(16'h00FF, 16'h0F01, 1'b0, 1'b0);
        wait_out("stall", lat);
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            a = 16'($urandom); b = 16'($urandom);
            @(negedge clk);
            check("stall_ready", 32'(in_ready), 32'(0));
            check("stall_s", 32'({out_valid, s}), 32'({1'b1, 16'h1000}));
            @(posedge clk);
            #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        check("stall_release", 32'({out_valid, s}), 32'({1'b1, 16'h1000}));
        repeat (ST + 2) @(posedge clk);
        #1;

        // Reset with 3 results in flight
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++)
            send(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
        wait_out("rstfl", lat);
        #2;
        rst_n = 1'b0;
        sb_q.delete();
        prev_stall = 1'b0;
        #1;
        check("rstfl_out_valid", 32'(out_valid), 32'(0));
        check("rstfl_outs", 32'({s, co, ovf}), 32'(0));
        check("rstfl_in_ready", 32'(in_ready), 32'(1));
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        cnt = 0;
        repeat (ST + 6) begin
            @(negedge clk);
            if (out_valid) cnt++;
        end
        check("rstfl_flushed", 32'(cnt), 32'(0));
        @(posedge clk);
        #1;
        run_one("post_rst", 16'h0101, 16'h0202, 1'b0, 1'b0, 16'h0303, 1'b0, 1'b0);

        // Randomized traffic with random back-pressure
        start = n_out;
        for (int i = 0; i < 40000 && (n_out - start) < 10000; i++) begin
            out_ready = ($urandom_range(0, 9) < 7);
            in_valid  = ($urandom_range(0, 9) < 7);
            a   = 16'($urandom);
            b   = 16'($urandom);
            ci  = 1'($urandom);
            sub = 1'($urandom);
            @(posedge clk);
            #1;
        end
        check("random_count", 32'((n_out - start) >= 10000), 32'(1));
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (ST + 3) @(posedge clk);
        #1;
        check("drain_empty", 32'(sb_q.size()), 32'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
